// File: rtl/adder_pkg.sv
// adder_pkg: shared types, slice sizing and signed limit helpers for pipelined_carry_adder
package adder_pkg;
    localparam int MAX_WIDTH = 1024;

    // Per-stage control travelling alongside the skewed operands.
    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctl_t;

    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic bit params_legal(input int width, input int stages);
        return width >= 2 && stages >= 1 && stages <= width && width % stages == 0;
    endfunction

    function automatic logic [MAX_WIDTH-1:0] signed_min(input int width);
        logic [MAX_WIDTH-1:0] m;
        m = '0;
        m[width-1] = 1'b1;
        return m;
    endfunction

    function automatic logic [MAX_WIDTH-1:0] signed_max(input int width);
        return signed_min(width) - MAX_WIDTH'(1);
    endfunction
endpackage

// File: rtl/pipelined_carry_adder_if.sv
// pipelined_carry_adder_if: operand/result handshake bundle for pipelined_carry_adder
// master drives in_valid/a/b/Cin/sub/out_ready; slave drives in_ready/out_valid/S/Cout/posOverflow/negOverflow.
interface pipelined_carry_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             Cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             posOverflow;
    logic             negOverflow;

    modport master (
        output in_valid, a, b, Cin, sub, out_ready,
        input  in_ready, out_valid, S, Cout, posOverflow, negOverflow
    );

    modport slave (
        input  in_valid, a, b, Cin, sub, out_ready,
        output in_ready, out_valid, S, Cout, posOverflow, negOverflow
    );
endinterface

// File: rtl/adder_chunk_slice.sv
// adder_chunk_slice: combinational W-bit ripple-carry slice
// Ports: a_i, b_i (W bits), ci_i carry-in; s_o (W bits) sum, co_o carry-out.
module adder_chunk_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         ci_i,
    output logic [W-1:0] s_o,
    output logic         co_o
);
    logic [W:0] c;

    always_comb begin
        c = '0;
        s_o = '0;
        c[0] = ci_i;
        for (int i = 0; i < W; i++) begin
            s_o[i] = a_i[i] ^ b_i[i] ^ c[i];
            c[i+1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign co_o = c[W];
endmodule

// File: rtl/pipelined_carry_adder.sv
// pipelined_carry_adder: WIDTH-bit add/subtract split into STAGES registered ripple slices
// Ports: clk; rst (synchronous, active-high); bus (slave modport) carrying
//        in_valid/in_ready/a/b/Cin/sub and out_valid/out_ready/S/Cout/posOverflow/negOverflow.
// Option: define PIPELINED_CARRY_ADDER_SATURATE_EN to clamp S to signed max/min on overflow.
module pipelined_carry_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input logic                   clk,
    input logic                   rst,
    pipelined_carry_adder_if.slave bus
);
    localparam int CHUNK = chunk_width(WIDTH, STAGES);

    if (!params_legal(WIDTH, STAGES)) begin : g_bad_params
        $error("pipelined_carry_adder: WIDTH must be >= 2 and a multiple of STAGES, 1 <= STAGES <= WIDTH");
    end

    logic             advance;
    logic             out_valid_q;
    logic             cout_q;
    logic             pos_q;
    logic             neg_q;
    logic [WIDTH-1:0] sum_q;

    // Global stall: every stage moves only when the output slot can be refilled.
    assign advance         = !out_valid_q || bus.out_ready;
    assign bus.in_ready    = advance;
    assign bus.out_valid   = out_valid_q;
    assign bus.S           = sum_q;
    assign bus.Cout        = cout_q;
    assign bus.posOverflow = pos_q;
    assign bus.negOverflow = neg_q;

    // Stage k consumes the lowest CHUNK bits of the operands still pending; the
    // unconsumed upper bits shrink stage by stage, and the finished sum grows,
    // so the operand MSBs (signs) arrive at the last stage in a_w/bx_w[CHUNK-1].
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int DONE = k * CHUNK;
        localparam int REM  = WIDTH - DONE;
        logic [REM-1:0]        a_w;
        logic [REM-1:0]        bx_w;
        stage_ctl_t            ctl_w;
        logic [CHUNK-1:0]      sc;
        logic                  co;
        logic [DONE+CHUNK-1:0] s_w;

        adder_chunk_slice #(.W(CHUNK)) u_slice (
            .a_i  (a_w[CHUNK-1:0]),
            .b_i  (bx_w[CHUNK-1:0]),
            .ci_i (ctl_w.carry),
            .s_o  (sc),
            .co_o (co)
        );

        if (k == 0) begin : g_in
            // Subtract as a + ~b + ~Cin.
            assign a_w   = bus.a;
            assign bx_w  = bus.b ^ {WIDTH{bus.sub}};
            assign ctl_w = {bus.in_valid, bus.sub ^ bus.Cin};
            assign s_w   = sc;
        end else begin : g_chain
            assign a_w   = g_stage[k-1].g_reg.a_q;
            assign bx_w  = g_stage[k-1].g_reg.bx_q;
            assign ctl_w = g_stage[k-1].g_reg.ctl_q;
            assign s_w   = {sc, g_stage[k-1].g_reg.s_q};
        end

        if (k < STAGES - 1) begin : g_reg
            stage_ctl_t            ctl_q;
            logic [REM-CHUNK-1:0]  a_q;
            logic [REM-CHUNK-1:0]  bx_q;
            logic [DONE+CHUNK-1:0] s_q;

            always_ff @(posedge clk) begin
                if (rst)
                    ctl_q <= '0;
                else if (advance)
                    ctl_q <= '{valid: ctl_w.valid, carry: co};
                if (advance) begin
                    a_q  <= a_w[REM-1:CHUNK];
                    bx_q <= bx_w[REM-1:CHUNK];
                    s_q  <= s_w;
                end
            end
        end else begin : g_out
            logic             pos_d;
            logic             neg_d;
            logic [WIDTH-1:0] s_d;

            assign pos_d = !a_w[CHUNK-1] && !bx_w[CHUNK-1] && s_w[WIDTH-1];
            assign neg_d = a_w[CHUNK-1] && bx_w[CHUNK-1] && !s_w[WIDTH-1];
`ifdef PIPELINED_CARRY_ADDER_SATURATE_EN
            assign s_d = pos_d ? WIDTH'(signed_max(WIDTH)) : neg_d ? WIDTH'(signed_min(WIDTH)) : s_w;
`else
            assign s_d = s_w;
`endif

            // Result fields only load with a valid slot, so they hold through bubbles.
            always_ff @(posedge clk) begin
                if (rst) begin
                    out_valid_q <= 1'b0;
                    sum_q       <= '0;
                    cout_q      <= 1'b0;
                    pos_q       <= 1'b0;
                    neg_q       <= 1'b0;
                end else if (advance) begin
                    out_valid_q <= ctl_w.valid;
                    if (ctl_w.valid) begin
                        sum_q  <= s_d;
                        cout_q <= co;
                        pos_q  <= pos_d;
                        neg_q  <= neg_d;
                    end
                end
            end
        end
    end
endmodule
